// File: rtl/dat_tx_framer.sv
// SD DAT0 transmit framer: start bit, MSB-first FIFO payload, optional CRC16, end bit.
// Define DAT_TX_CRC_EN to include the CRC16-CCITT stage between payload and end bit.
module dat_tx_framer #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sd_tick,
    input  logic              start,
    input  logic [3:0]        blockSize,
    input  logic [WORD_W-1:0] fromFifo_toPS,
    input  logic              fifo_empty,
    output logic              pop,
    output logic              dat_out,
    output logic              dat_oe,
    output logic              busy,
    output logic              block_done,
    output logic              underrun
);
    typedef enum logic [2:0] {StIdle, StStart, StData, StCrc, StEnd, StDone} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [4:0]        word_cnt_q, word_cnt_d;
    logic              abort_q, abort_d;
    logic              pop_q, pop_d;
    logic              dat_out_q, dat_out_d;
    logic              dat_oe_q, dat_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
`ifdef DAT_TX_CRC_EN
    logic [15:0]       crc_q, crc_d, crc_next;

    // The bit on the line completes at this tick; fold it into the CRC.
    always_comb begin
        crc_next = {crc_q[14:0], 1'b0};
        if (crc_q[15] ^ dat_out_q) begin
            crc_next = crc_next ^ 16'h1021;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        abort_d    = abort_q;
        pop_d      = 1'b0;
        dat_out_d  = dat_out_q;
        dat_oe_d   = dat_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
`ifdef DAT_TX_CRC_EN
        crc_d      = crc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (!fifo_empty) begin
                        word_cnt_d = (blockSize == 4'd0) ? 5'd16 : {1'b0, blockSize};
                        pop_d      = 1'b1;
                        busy_d     = 1'b1;
                        abort_d    = 1'b0;
`ifdef DAT_TX_CRC_EN
                        crc_d      = 16'h0000;
`endif
                        state_d    = StStart;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            StStart: begin
                if (sd_tick) begin
                    if (!dat_oe_q) begin
                        dat_oe_d  = 1'b1;
                        dat_out_d = 1'b0;
                    end else begin
                        shift_d   = fromFifo_toPS;
                        dat_out_d = fromFifo_toPS[WORD_W-1];
                        bit_cnt_d = 5'd31;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (sd_tick) begin
`ifdef DAT_TX_CRC_EN
                    crc_d = crc_next;
`endif
                    if (bit_cnt_q != 5'd0) begin
                        shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                        dat_out_d = shift_q[WORD_W-2];
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        // Request the next word two bits early so it is stable at load time.
                        if (bit_cnt_q == 5'd2 && word_cnt_q != 5'd1) begin
                            if (fifo_empty) begin
                                underrun_d = 1'b1;
                                abort_d    = 1'b1;
                            end else begin
                                pop_d = 1'b1;
                            end
                        end
                    end else begin
                        word_cnt_d = word_cnt_q - 5'd1;
                        if (abort_q) begin
                            dat_oe_d  = 1'b0;
                            dat_out_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = StIdle;
                        end else if (word_cnt_q == 5'd1) begin
`ifdef DAT_TX_CRC_EN
                            crc_d     = {crc_next[14:0], 1'b0};
                            dat_out_d = crc_next[15];
                            bit_cnt_d = 5'd15;
                            state_d   = StCrc;
`else
                            dat_out_d = 1'b1;
                            state_d   = StEnd;
`endif
                        end else begin
                            shift_d   = fromFifo_toPS;
                            dat_out_d = fromFifo_toPS[WORD_W-1];
                            bit_cnt_d = 5'd31;
                        end
                    end
                end
            end
`ifdef DAT_TX_CRC_EN
            StCrc: begin
                if (sd_tick) begin
                    if (bit_cnt_q != 5'd0) begin
                        dat_out_d = crc_q[15];
                        crc_d     = {crc_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else begin
                        dat_out_d = 1'b1;
                        state_d   = StEnd;
                    end
                end
            end
`endif
            StEnd: begin
                if (sd_tick) begin
                    dat_oe_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= 5'd0;
            word_cnt_q <= 5'd0;
            abort_q    <= 1'b0;
            pop_q      <= 1'b0;
            dat_out_q  <= 1'b1;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef DAT_TX_CRC_EN
            crc_q      <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            abort_q    <= abort_d;
            pop_q      <= pop_d;
            dat_out_q  <= dat_out_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
`ifdef DAT_TX_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign pop        = pop_q;
    assign dat_out    = dat_out_q;
    assign dat_oe     = dat_oe_q;
    assign busy       = busy_q;
    assign block_done = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dat_tx_framer.sv
// Scoreboard bench for dat_tx_framer: a bit-level frame model fills a queue of expected
// line values, and a monitor pops and compares one entry per driven sd_tick.
module tb_dat_tx_framer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sd_tick = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  blockSize = 4'd0;
    logic [31:0] fromFifo_toPS = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        pop, dat_out, dat_oe, busy, block_done, underrun;

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int tick_cnt = 0;
    bit tick_rand = 1'b0;
    logic [31:0] fifo_q[$];
    bit          exp_bits[$];
    int n_driven = 0, n_pop = 0, n_done = 0, n_under = 0;
    logic prev_out = 1'b1, prev_oe = 1'b0;

    always #5 clock = ~clock;

    dat_tx_framer #(.WORD_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .sd_tick      (sd_tick),
        .start        (start),
        .blockSize    (blockSize),
        .fromFifo_toPS(fromFifo_toPS),
        .fifo_empty   (fifo_empty),
        .pop          (pop),
        .dat_out      (dat_out),
        .dat_oe       (dat_oe),
        .busy         (busy),
        .block_done   (block_done),
        .underrun     (underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        tick_cnt = tick_cnt + 1;
        if (tick_rand) sd_tick = ($urandom_range(0, 2) == 0);
        else           sd_tick = ((tick_cnt % tick_div) == 0);
    end

    // FIFO model: a pop presents the next stored word on the following edge.
    always @(posedge clock) begin
        if (pop && fifo_q.size() > 0) fromFifo_toPS <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(posedge clock) begin : monitor
        logic tk;
        bit   e;
        tk = sd_tick;
        #1;
        if (reset) begin
            if (pop)        n_pop++;
            if (block_done) n_done++;
            if (underrun)   n_under++;
            if (dat_out !== prev_out || dat_oe !== prev_oe) begin
                checks++;
                if (!tk) begin
                    errors++;
                    $display("FAIL line_change_off_tick: out=%b oe=%b changed without sd_tick",
                             dat_out, dat_oe);
                end
            end
            if (tk && dat_oe) begin
                n_driven++;
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %b at tick %0d, expected none", dat_out,
                             n_driven);
                end else begin
                    e = exp_bits.pop_front();
                    check($sformatf("dat_out tick %0d", n_driven), 32'(dat_out), 32'(e));
                end
            end
        end
        prev_out = dat_out;
        prev_oe  = dat_oe;
    end

    // CRC16-CCITT as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_div(input bit msg[$]);
        bit          r[$];
        logic [16:0] poly;
        logic [15:0] rem;
        poly = 17'h11021;
        r = msg;
        for (int i = 0; i < 16; i++) r.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (r[i]) begin
                for (int j = 0; j < 17; j++) r[i+j] = r[i+j] ^ poly[16-j];
            end
        end
        for (int j = 0; j < 16; j++) rem[15-j] = r[msg.size()+j];
        return rem;
    endfunction

    task automatic model_block(input logic [31:0] words[$], input bit abort);
        bit msg[$];
`ifdef DAT_TX_CRC_EN
        logic [15:0] c;
`endif
        exp_bits.push_back(1'b0);
        foreach (words[i]) begin
            for (int b = 31; b >= 0; b--) begin
                msg.push_back(words[i][b]);
                exp_bits.push_back(words[i][b]);
            end
        end
        if (!abort) begin
`ifdef DAT_TX_CRC_EN
            c = crc_div(msg);
            for (int b = 15; b >= 0; b--) exp_bits.push_back(c[b]);
`endif
            exp_bits.push_back(1'b1);
        end
    endtask

    function automatic int frame_len(input int nwords, input bit abort);
        int len;
        len = 1 + 32 * nwords;
        if (!abort) begin
`ifdef DAT_TX_CRC_EN
            len = len + 16;
`endif
            len = len + 1;
        end
        return len;
    endfunction

    task automatic run_block(input logic [3:0] bs, input logic [31:0] words[$], input int div,
                             input bit rnd, input string tag);
        int need, cyc;
        bit abort;
        need  = (bs == 4'd0) ? 16 : int'(bs);
        abort = (words.size() < need);
        tick_div  = div;
        tick_rand = rnd;
        n_driven = 0; n_pop = 0; n_done = 0; n_under = 0;
        foreach (words[i]) fifo_q.push_back(words[i]);
        model_block(words, abort);
        repeat (2) @(negedge clock);
        start = 1'b1;
        blockSize = bs;
        @(negedge clock);
        start = 1'b0;
        blockSize = 4'($urandom);
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, " busy_cleared"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        check({tag, " driven_ticks"}, 32'(n_driven), 32'(frame_len(words.size(), abort)));
        check({tag, " bits_left"}, 32'(exp_bits.size()), 32'd0);
        check({tag, " pops"}, 32'(n_pop), 32'(words.size()));
        check({tag, " block_done"}, 32'(n_done), abort ? 32'd0 : 32'd1);
        check({tag, " underrun"}, 32'(n_under), abort ? 32'd1 : 32'd0);
        check({tag, " oe_idle"}, 32'(dat_oe), 32'd0);
        check({tag, " out_idle"}, 32'(dat_out), 32'd1);
        exp_bits.delete();
    endtask

    initial begin
        logic [31:0] w[$];
        int cyc;
        logic [3:0] bs;

        repeat (3) @(negedge clock);
        check("rst dat_out", 32'(dat_out), 32'd1);
        check("rst dat_oe", 32'(dat_oe), 32'd0);
        check("rst pop", 32'(pop), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst block_done", 32'(block_done), 32'd0);
        check("rst underrun", 32'(underrun), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Start with an empty FIFO: underrun only, no block.
        n_under = 0; n_pop = 0;
        start = 1'b1; blockSize = 4'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("empty_start underrun", 32'(n_under), 32'd1);
        check("empty_start busy", 32'(busy), 32'd0);
        check("empty_start pops", 32'(n_pop), 32'd0);

        w = '{32'hC0000003};
        run_block(4'd1, w, 1, 1'b0, "bs1");
        w = '{32'hC0000003, 32'hC000E000};
        run_block(4'd2, w, 3, 1'b0, "bs2");
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        run_block(4'd0, w, 2, 1'b0, "bs16");
        w = '{$urandom};
        run_block(4'd3, w, 1, 1'b0, "underrun");

        // Start during DATA is ignored; reset mid-frame forces idle outputs at once.
        tick_div = 1; tick_rand = 1'b0;
        n_driven = 0; n_pop = 0; n_done = 0; n_under = 0;
        w = '{$urandom};
        fifo_q.push_back(w[0]);
        fifo_q.push_back($urandom);
        model_block(w, 1'b0);
        repeat (2) @(negedge clock);
        start = 1'b1; blockSize = 4'd1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (n_driven < 10 && cyc < 200) begin @(negedge clock); cyc++; end
        check("mid reach_data", 32'(n_driven >= 10), 32'd1);
        start = 1'b1; blockSize = 4'd4;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
`ifdef DAT_TX_CRC_EN
        while (n_driven < 37 && cyc < 200) begin @(negedge clock); cyc++; end
`else
        while (n_driven < 20 && cyc < 200) begin @(negedge clock); cyc++; end
`endif
        check("mid busy", 32'(busy), 32'd1);
        check("mid ignored_start pops", 32'(n_pop), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst dat_oe", 32'(dat_oe), 32'd0);
        check("async_rst dat_out", 32'(dat_out), 32'd1);
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst block_done", 32'(n_done), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_bits.delete();
        fifo_q.delete();
        repeat (3) @(negedge clock);

        for (int k = 0; k < 6; k++) begin
            bs = 4'($urandom_range(1, 4));
            w.delete();
            for (int i = 0; i < int'(bs); i++) w.push_back($urandom);
            run_block(bs, w, 1, 1'b1, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
